// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the 2:1 arbiter slice.
// Transfer-type encoding, response codes and the address-phase bundle.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int AHB_AW = 32;
    localparam int AHB_BW = 3;
    localparam int AHB_PW = 4;

    typedef struct packed {
        logic [AHB_AW-1:0] haddr;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [AHB_BW-1:0] hburst;
        logic [AHB_PW-1:0] hprot;
        logic              hmastlock;
        htrans_t           htrans;
    } ahb_addr_t;

    // BUSY/SEQ mean the owner is mid-burst and must keep the bus
    function automatic logic in_burst(htrans_t t);
        return t inside {BUSY, SEQ};
    endfunction

endpackage

// File: rtl/ahb_arbiter_2to1_if.sv
// AHB-Lite port bundle shared by upstream masters and the downstream slave.
// master drives the address/data phase, slave returns ready/resp/rdata.
interface ahb_arbiter_2to1_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int HPROT_WIDTH  = 4
);
    logic [1:0]              HTRANS;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [HBURST_WIDTH-1:0] HBURST;
    logic [HPROT_WIDTH-1:0]  HPROT;
    logic                    HMASTLOCK;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic                    HREADYOUT;
    logic                    HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;

    modport master (
        output HTRANS, HADDR, HWRITE, HSIZE, HBURST,
        output HPROT, HMASTLOCK, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HTRANS, HADDR, HWRITE, HSIZE, HBURST,
        input  HPROT, HMASTLOCK, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_arb_hold.sv
// Per-port hold register: captures a losing address phase until it is
// granted, and selects held or live address as the port's source.
module ahb_arb_hold
    import ahb_pkg::*;
#(
    parameter type addr_t = ahb_addr_t
) (
    input  logic  HCLK,
    input  logic  HRESETn,
    input  addr_t live,
    input  logic  load,
    input  logic  clr,
    output logic  pend,
    output addr_t src
);

    addr_t hold_q;
    logic  pend_q;

    // load and clr never coincide: load needs HREADYOUT=1, i.e. pend=0
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q <= 1'b0;
            hold_q <= '0;
        end else if (load) begin
            pend_q <= 1'b1;
            hold_q <= live;
        end else if (clr) begin
            pend_q <= 1'b0;
        end
    end

    assign pend = pend_q;
    assign src  = pend_q ? hold_q : live;

endmodule

// File: rtl/ahb_arbiter_2to1.sv
// Two-master AHB-Lite arbiter onto one downstream port. Losers are held
// and stalled; locked sequences and bursts are never broken.
module ahb_arbiter_2to1 #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int HPROT_WIDTH  = 4,
    parameter int PRIO_MODE    = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_arbiter_2to1_if.slave  s0,
    ahb_arbiter_2to1_if.slave  s1,
    ahb_arbiter_2to1_if.master m,
    output logic              HMASTERM
);
    import ahb_pkg::*;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   haddr;
        logic                    hwrite;
        logic [2:0]              hsize;
        logic [HBURST_WIDTH-1:0] hburst;
        logic [HPROT_WIDTH-1:0]  hprot;
        logic                    hmastlock;
        htrans_t                 htrans;
    } addr_ph_t;

    addr_ph_t live0, live1;
    addr_ph_t src0, src1;
    addr_ph_t src_own, src_gnt;

    logic own_q;
    logic dph_vld_q;
    logic gnt;
    logic pend0, pend1;
    logic dph0, dph1;
    logic rdy0, rdy1;
    logic rl0, rl1;
    logic rq0, rq1;
    logic rq_gnt;
    logic own_hold;
    logic ld0, ld1;
    logic cl0, cl1;

    assign live0 = '{
        haddr:     s0.HADDR,
        hwrite:    s0.HWRITE,
        hsize:     s0.HSIZE,
        hburst:    s0.HBURST,
        hprot:     s0.HPROT,
        hmastlock: s0.HMASTLOCK,
        htrans:    htrans_t'(s0.HTRANS)
    };

    assign live1 = '{
        haddr:     s1.HADDR,
        hwrite:    s1.HWRITE,
        hsize:     s1.HSIZE,
        hburst:    s1.HBURST,
        hprot:     s1.HPROT,
        hmastlock: s1.HMASTLOCK,
        htrans:    htrans_t'(s1.HTRANS)
    };

    ahb_arb_hold #(.addr_t(addr_ph_t)) u_hold0 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .live    (live0),
        .load    (ld0),
        .clr     (cl0),
        .pend    (pend0),
        .src     (src0)
    );

    ahb_arb_hold #(.addr_t(addr_ph_t)) u_hold1 (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .live    (live1),
        .load    (ld1),
        .clr     (cl1),
        .pend    (pend1),
        .src     (src1)
    );

    assign dph0 = dph_vld_q & ~own_q;
    assign dph1 = dph_vld_q & own_q;

    assign rdy0 = pend0 ? 1'b0 : (dph0 ? m.HREADYOUT : 1'b1);
    assign rdy1 = pend1 ? 1'b0 : (dph1 ? m.HREADYOUT : 1'b1);

    assign rl0 = s0.HTRANS[1] & rdy0;
    assign rl1 = s1.HTRANS[1] & rdy1;
    assign rq0 = pend0 | rl0;
    assign rq1 = pend1 | rl1;

    // the last address-phase owner keeps the bus while locked or mid-burst
    assign src_own  = own_q ? src1 : src0;
    assign own_hold = src_own.hmastlock | in_burst(src_own.htrans);

    always_comb begin
        gnt = own_q;
        if (m.HREADYOUT && !own_hold) begin
            if (rq0 && rq1) begin
                gnt = (PRIO_MODE != 0) ? 1'b0 : ~own_q;
            end else if (rq0) begin
                gnt = 1'b0;
            end else if (rq1) begin
                gnt = 1'b1;
            end
        end
    end

    assign src_gnt = gnt ? src1 : src0;
    assign rq_gnt  = gnt ? rq1 : rq0;

    assign ld0 = rl0 & ~(~gnt & m.HREADYOUT);
    assign ld1 = rl1 & ~(gnt & m.HREADYOUT);
    assign cl0 = m.HREADYOUT & ~gnt & pend0;
    assign cl1 = m.HREADYOUT & gnt & pend1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            own_q     <= 1'b0;
            dph_vld_q <= 1'b0;
        end else if (m.HREADYOUT) begin
            own_q     <= gnt;
            dph_vld_q <= m.HTRANS[1];
        end
    end

    assign m.HTRANS    = rq_gnt ? src_gnt.htrans : IDLE;
    assign m.HADDR     = src_gnt.haddr;
    assign m.HWRITE    = src_gnt.hwrite;
    assign m.HSIZE     = src_gnt.hsize;
    assign m.HBURST    = src_gnt.hburst;
    assign m.HPROT     = src_gnt.hprot;
    assign m.HMASTLOCK = src_gnt.hmastlock;
    assign m.HWDATA    = own_q ? s1.HWDATA : s0.HWDATA;

    assign HMASTERM = own_q;

    assign s0.HREADYOUT = rdy0;
    assign s1.HREADYOUT = rdy1;
    assign s0.HRESP     = dph0 ? m.HRESP : HRESP_OKAY;
    assign s1.HRESP     = dph1 ? m.HRESP : HRESP_OKAY;
    assign s0.HRDATA    = m.HRDATA;
    assign s1.HRDATA    = m.HRDATA;

endmodule
